// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: status codes and the data-memory access FSM states.
package y86_pkg;

  localparam logic [3:0] STAT_AOK = 4'b1000;
  localparam logic [3:0] STAT_HLT = 4'b0001;
  localparam logic [3:0] STAT_ADR = 4'b0010;
  localparam logic [3:0] STAT_INS = 4'b0100;

  typedef enum logic [1:0] {
    DMEM_IDLE = 2'd0,
    DMEM_BUSY = 2'd1,
    DMEM_RESP = 2'd2
  } dmem_state_e;

endpackage

// File: rtl/dmem_array.sv
// Byte-addressed data array: 64-bit little-endian combinational read,
// synchronous 8-byte write. No reset, so contents survive a pipeline reset.
module dmem_array #(
  parameter int unsigned MEM_BYTES = 1024,
  localparam int unsigned AW = $clog2(MEM_BYTES)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [63:0]   wdata,
  output logic [63:0]   rdata
);

  logic [7:0] mem [0:MEM_BYTES-1];

  always_comb begin
    rdata = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      rdata[8*i +: 8] = mem[addr + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int unsigned i = 0; i < 8; i++) begin
        mem[addr + AW'(i)] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/dmem_unit.sv
// Multi-cycle handshaked data memory for the Memory stage: one access in flight,
// fixed LATENCY, ADR status for addresses whose 8-byte window leaves the array.
module dmem_unit
  import y86_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_write,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        req_ready,
  output logic        resp_valid,
  output logic [63:0] resp_rdata,
  output logic [3:0]  resp_stat,
  output logic        mem_stall
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  dmem_state_e state, next_state;
  logic [3:0]  cnt, cnt_next;
  logic        lat_write;
  logic [63:0] lat_addr;
  logic [63:0] lat_wdata;

  logic        eff_write;
  logic [63:0] eff_addr;
  logic [63:0] eff_wdata;
  logic        addr_ok;
  logic        enter_resp;
  logic        arr_we;
  logic [63:0] arr_rdata;

  // With LATENCY=1 RESP is entered straight from IDLE, before anything is
  // latched, so the access path reads the live request while IDLE.
  always_comb begin
    if (state == DMEM_IDLE) begin
      eff_write = req_write;
      eff_addr  = req_addr;
      eff_wdata = req_wdata;
    end else begin
      eff_write = lat_write;
      eff_addr  = lat_addr;
      eff_wdata = lat_wdata;
    end
  end

  assign addr_ok = (eff_addr <= 64'(MEM_BYTES - 8));

  always_comb begin
    next_state = state;
    cnt_next   = cnt;
    case (state)
      DMEM_IDLE: begin
        if (req_valid) begin
          cnt_next   = 4'(LATENCY - 1);
          next_state = (LATENCY == 1) ? DMEM_RESP : DMEM_BUSY;
        end
      end
      DMEM_BUSY: begin
        // Leave when this decrement brings the count to zero.
        cnt_next = cnt - 4'd1;
        if (cnt == 4'd1) next_state = DMEM_RESP;
      end
      DMEM_RESP: begin
        cnt_next   = '0;
        next_state = DMEM_IDLE;
      end
      default: begin
        cnt_next   = '0;
        next_state = DMEM_IDLE;
      end
    endcase
  end

  assign enter_resp = (next_state == DMEM_RESP) && (state != DMEM_RESP);
  assign arr_we     = enter_resp && eff_write && addr_ok && !reset;

  dmem_array #(.MEM_BYTES(MEM_BYTES)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .addr  (eff_addr[AW-1:0]),
    .wdata (eff_wdata),
    .rdata (arr_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= DMEM_IDLE;
      cnt        <= '0;
      lat_write  <= 1'b0;
      lat_addr   <= '0;
      lat_wdata  <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_stat  <= STAT_AOK;
      mem_stall  <= 1'b0;
    end else begin
      state      <= next_state;
      cnt        <= cnt_next;
      req_ready  <= (next_state == DMEM_IDLE);
      resp_valid <= (next_state == DMEM_RESP);
      mem_stall  <= (next_state == DMEM_BUSY);
      if (state == DMEM_IDLE && req_valid) begin
        lat_write <= req_write;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
      end
      if (enter_resp) begin
        resp_rdata <= (addr_ok && !eff_write) ? arr_rdata : '0;
        resp_stat  <= addr_ok ? STAT_AOK : STAT_ADR;
      end else begin
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_dmem_unit.sv
// Self-checking bench for dmem_unit: byte-array reference model, directed
// boundary/reset/hold scenarios, randomized accesses, LATENCY 1/2/4 instances.
module tb_dmem_unit;
  import y86_pkg::*;

  localparam int unsigned MB = 1024;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;

  logic        m_ready, m_resp_valid, m_stall;
  logic [63:0] m_rdata;
  logic [3:0]  m_stat;
  logic        a_ready, a_resp_valid, a_stall;
  logic [63:0] a_rdata;
  logic [3:0]  a_stat;
  logic        b_ready, b_resp_valid, b_stall;
  logic [63:0] b_rdata;
  logic [3:0]  b_stat;

  dmem_unit #(.MEM_BYTES(MB), .LATENCY(2)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(m_ready),
    .resp_valid(m_resp_valid), .resp_rdata(m_rdata), .resp_stat(m_stat),
    .mem_stall(m_stall));

  dmem_unit #(.MEM_BYTES(MB), .LATENCY(1)) dut_l1 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(a_ready),
    .resp_valid(a_resp_valid), .resp_rdata(a_rdata), .resp_stat(a_stat),
    .mem_stall(a_stall));

  dmem_unit #(.MEM_BYTES(MB), .LATENCY(4)) dut_l4 (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_ready(b_ready),
    .resp_valid(b_resp_valid), .resp_rdata(b_rdata), .resp_stat(b_stat),
    .mem_stall(b_stall));

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;
  logic [7:0] ref_mem [0:MB-1];

  function automatic bit ref_ok(input logic [63:0] a);
    return a <= 64'(MB - 8);
  endfunction

  function automatic logic [63:0] ref_load(input logic [63:0] a);
    logic [63:0] r;
    r = '0;
    if (!ref_ok(a)) return '0;
    for (int k = 0; k < 8; k++) r = r | (64'(ref_mem[int'(a) + k]) << (8 * k));
    return r;
  endfunction

  function automatic void ref_store(input logic [63:0] a, input logic [63:0] d);
    if (!ref_ok(a)) return;
    for (int k = 0; k < 8; k++) ref_mem[int'(a) + k] = 8'((d >> (8 * k)) & 64'hFF);
  endfunction

  function automatic logic [63:0] rand64();
    return {$urandom(), $urandom()};
  endfunction

  // Issues one request on the main instance and waits for its response.
  task automatic access(input bit wr, input logic [63:0] addr, input logic [63:0] wdata,
                        output logic [63:0] rdata, output logic [3:0] stat,
                        output int lat, output int stalls, output bit got);
    int guard;
    got = 1'b0; lat = 0; stalls = 0; rdata = 'x; stat = 'x;
    @(negedge clk);
    guard = 0;
    while (!m_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!m_ready) begin
      n_cmp++; n_bad++;
      $display("FAIL ready_timeout: req_ready stayed %b, required 1", m_ready);
      return;
    end
    req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    for (int i = 0; i < 20 && !got; i++) begin
      @(negedge clk);
      lat++;
      req_valid = 1'b0;
      if (m_resp_valid) begin
        got = 1'b1; rdata = m_rdata; stat = m_stat;
      end else if (m_stall) begin
        stalls++;
      end
    end
    if (!got) begin
      n_cmp++; n_bad++;
      $display("FAIL resp_timeout: no resp_valid within 20 cycles for addr %h", addr);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (m_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", m_ready); end
    n_cmp++; if (m_resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_resp_valid: got %b want 0", m_resp_valid); end
    n_cmp++; if (m_rdata !== 64'h0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", m_rdata); end
    n_cmp++; if (m_stat !== STAT_AOK) begin n_bad++; $display("FAIL reset_stat: got %b want %b", m_stat, STAT_AOK); end
    n_cmp++; if (m_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", m_stall); end
    n_cmp++; if (a_ready !== 1'b1 || b_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_lat: got %b/%b want 1/1", a_ready, b_ready); end
    reset = 1'b0;
  endtask

  task automatic test_init();
    logic [63:0] rd, d; logic [3:0] st; int lat, stl; bit got;
    for (int w = 0; w < 16; w++) begin
      d = rand64();
      access(1'b1, 64'(8 * w), d, rd, st, lat, stl, got);
      ref_store(64'(8 * w), d);
      if (got) begin
        n_cmp++; if (st !== STAT_AOK || rd !== 64'h0) begin n_bad++; $display("FAIL init_store: stat %b rdata %h want %b 0", st, rd, STAT_AOK); end
      end
    end
  endtask

  task automatic test_store_load();
    logic [63:0] rd; logic [3:0] st; int lat, stl; bit got;
    access(1'b1, 64'd16, 64'h0123456789ABCDEF, rd, st, lat, stl, got);
    ref_store(64'd16, 64'h0123456789ABCDEF);
    if (got) begin
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL store_latency: got %0d want 2", lat); end
      n_cmp++; if (stl != 1) begin n_bad++; $display("FAIL store_stall_cycles: got %0d want 1", stl); end
      n_cmp++; if (st !== STAT_AOK) begin n_bad++; $display("FAIL store_stat: got %b want %b", st, STAT_AOK); end
    end
    access(1'b0, 64'd16, 64'h0, rd, st, lat, stl, got);
    if (got) begin
      n_cmp++; if (rd !== 64'h0123456789ABCDEF) begin n_bad++; $display("FAIL load16: got %h want 0123456789abcdef", rd); end
    end
    @(negedge clk);
    n_cmp++; if (m_rdata !== 64'h0) begin n_bad++; $display("FAIL rdata_clear: got %h want 0", m_rdata); end
  endtask

  task automatic test_unaligned();
    logic [63:0] rd, d; logic [3:0] st; int lat, stl; bit got;
    d = {rand64()} & ~64'hFF | 64'h5A;
    access(1'b1, 64'd24, d, rd, st, lat, stl, got);
    ref_store(64'd24, d);
    access(1'b0, 64'd19, 64'h0, rd, st, lat, stl, got);
    if (got) begin
      n_cmp++; if (rd !== ref_load(64'd19)) begin n_bad++; $display("FAIL load19: got %h want %h", rd, ref_load(64'd19)); end
      n_cmp++; if (rd[47:40] !== 8'h5A) begin n_bad++; $display("FAIL load19_byte5: got %h want 5a", rd[47:40]); end
    end
  endtask

  task automatic test_bounds();
    logic [63:0] rd, d; logic [3:0] st; int lat, stl; bit got;
    d = rand64();
    access(1'b1, 64'(MB - 8), d, rd, st, lat, stl, got);
    ref_store(64'(MB - 8), d);
    access(1'b0, 64'(MB - 8), 64'h0, rd, st, lat, stl, got);
    if (got) begin
      n_cmp++; if (st !== STAT_AOK || rd !== d) begin n_bad++; $display("FAIL top_load: stat %b rdata %h want %b %h", st, rd, STAT_AOK, d); end
    end
    access(1'b0, 64'(MB - 7), 64'h0, rd, st, lat, stl, got);
    if (got) begin
      n_cmp++; if (st !== STAT_ADR || rd !== 64'h0) begin n_bad++; $display("FAIL over_load: stat %b rdata %h want %b 0", st, rd, STAT_ADR); end
      n_cmp++; if (lat != 2) begin n_bad++; $display("FAIL adr_latency: got %0d want 2", lat); end
    end
    access(1'b1, 64'hFFFF_FFFF_FFFF_FFFC, 64'hDEAD_BEEF_CAFE_F00D, rd, st, lat, stl, got);
    if (got) begin
      n_cmp++; if (st !== STAT_ADR || rd !== 64'h0) begin n_bad++; $display("FAIL wrap_store: stat %b rdata %h want %b 0", st, rd, STAT_ADR); end
    end
    access(1'b0, 64'h0, 64'h0, rd, st, lat, stl, got);
    if (got) begin
      n_cmp++; if (rd !== ref_load(64'h0)) begin n_bad++; $display("FAIL no_wrap_mem0: got %h want %h", rd, ref_load(64'h0)); end
    end
  endtask

  task automatic test_reset_busy();
    logic [63:0] rd; logic [3:0] st; int lat, stl; bit got;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'h0; req_wdata = '1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    n_cmp++; if (m_stall !== 1'b1) begin n_bad++; $display("FAIL busy_stall: got %b want 1", m_stall); end
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    n_cmp++;
    if (m_resp_valid !== 1'b0 || m_ready !== 1'b1 || m_stall !== 1'b0 || m_rdata !== 64'h0 || m_stat !== STAT_AOK) begin
      n_bad++;
      $display("FAIL abort_outputs: valid %b ready %b stall %b rdata %h stat %b want 0 1 0 0 %b",
               m_resp_valid, m_ready, m_stall, m_rdata, m_stat, STAT_AOK);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_cmp++; if (m_resp_valid !== 1'b0) begin n_bad++; $display("FAIL abort_no_resp: got %b want 0", m_resp_valid); end
    end
    access(1'b0, 64'h0, 64'h0, rd, st, lat, stl, got);
    if (got) begin
      n_cmp++; if (rd !== ref_load(64'h0)) begin n_bad++; $display("FAIL abort_mem0: got %h want %h", rd, ref_load(64'h0)); end
    end
  endtask

  task automatic test_random();
    logic [63:0] rd, a, d; logic [3:0] st; int lat, stl; bit got, wr;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0, 1: a = 64'($urandom_range(0, 120));
        2:    a = 64'(MB - 8 + $urandom_range(0, 7));
        default: a = rand64() | 64'h1_0000_0000;
      endcase
      wr = 1'($urandom_range(0, 1));
      d = rand64();
      access(wr, a, d, rd, st, lat, stl, got);
      if (got) begin
        n_cmp++;
        if (st !== (ref_ok(a) ? STAT_AOK : STAT_ADR) || rd !== (wr ? 64'h0 : ref_load(a)) || lat != 2 || stl != 1) begin
          n_bad++;
          $display("FAIL random_op: wr %b addr %h stat %b rdata %h lat %0d stall %0d want %b %h 2 1",
                   wr, a, st, rd, lat, stl, ref_ok(a) ? STAT_AOK : STAT_ADR, wr ? 64'h0 : ref_load(a));
        end
      end
      if (wr) ref_store(a, d);
    end
  endtask

  task automatic test_latency();
    int a_at, b_at, m_at, a_st, b_st, m_st;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd8; req_wdata = 64'h1111_2222_3333_4444;
    @(posedge clk);
    ref_store(64'd8, 64'h1111_2222_3333_4444);
    a_at = 0; b_at = 0; m_at = 0; a_st = 0; b_st = 0; m_st = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (a_at == 0) begin
        if (a_resp_valid) begin
          a_at = i;
          n_cmp++; if (a_ready !== 1'b0) begin n_bad++; $display("FAIL l1_ready_in_resp: got %b want 0", a_ready); end
        end else if (a_stall) a_st++;
      end
      if (b_at == 0) begin
        if (b_resp_valid) begin
          b_at = i;
          n_cmp++; if (b_ready !== 1'b0) begin n_bad++; $display("FAIL l4_ready_in_resp: got %b want 0", b_ready); end
        end else if (b_stall) b_st++;
      end
      if (m_at == 0) begin
        if (m_resp_valid) m_at = i;
        else if (m_stall) m_st++;
      end
    end
    n_cmp++; if (a_at != 1 || a_st != 0) begin n_bad++; $display("FAIL l1_timing: lat %0d stall %0d want 1 0", a_at, a_st); end
    n_cmp++; if (b_at != 4 || b_st != 3) begin n_bad++; $display("FAIL l4_timing: lat %0d stall %0d want 4 3", b_at, b_st); end
    n_cmp++; if (m_at != 2 || m_st != 1) begin n_bad++; $display("FAIL l2_timing: lat %0d stall %0d want 2 1", m_at, m_st); end
  endtask

  task automatic test_hold();
    logic [63:0] aa, ab, ac;
    bit got;
    aa = 64'($urandom_range(0, 60));
    ab = 64'($urandom_range(61, 120));
    ac = 64'($urandom_range(0, 120));
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = aa;
    @(posedge clk);
    @(negedge clk);
    req_addr = ab; req_write = 1'b1; req_wdata = rand64();
    @(negedge clk);
    n_cmp++; if (m_resp_valid !== 1'b1 || m_rdata !== ref_load(aa)) begin n_bad++; $display("FAIL hold_first: valid %b rdata %h want 1 %h", m_resp_valid, m_rdata, ref_load(aa)); end
    req_addr = ac; req_write = 1'b0;
    @(negedge clk);
    n_cmp++; if (m_ready !== 1'b1 || m_resp_valid !== 1'b0) begin n_bad++; $display("FAIL hold_gap: ready %b valid %b want 1 0", m_ready, m_resp_valid); end
    @(posedge clk);
    got = 1'b0;
    for (int i = 1; i <= 10 && !got; i++) begin
      @(negedge clk);
      req_valid = 1'b0;
      if (m_resp_valid) begin
        got = 1'b1;
        n_cmp++; if (i != 2 || m_rdata !== ref_load(ac)) begin n_bad++; $display("FAIL hold_second: lat %0d rdata %h want 2 %h", i, m_rdata, ref_load(ac)); end
      end
    end
    if (!got) begin n_cmp++; n_bad++; $display("FAIL hold_timeout: no second response, want one"); end
  endtask

  initial begin
    test_reset();
    test_init();
    test_store_load();
    test_unaligned();
    test_bounds();
    test_reset_busy();
    test_random();
    test_hold();
    test_latency();
    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
